keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Drives and decodes a 4x4 active-low matrix keypad. Produces the 4-bit key code consumed as keyPadBuf by the tic-tac-toe game core.
- Scans one column at a time, debounces press and release, and emits a single-cycle strobe per accepted press.
- Sits between the board keypad pins and the game core. Runs on the same clock domain as its consumer, so no synchroniser is needed on keyPadBuf.

Parameters:
- SETTLE, 2: cycles a column is driven before its rows are sampled (min 1).
- DEB, 4: consecutive identical samples needed to accept a press or a release (min 1).
- CNT_W, 4: width of the shared settle/debounce counter; must hold max(SETTLE, DEB).

Ports:
- clock  input  1  system clock
- rst  input  1  synchronous active-high reset
- row_in  input  4  keypad rows, active-low, externally pulled up; already synchronised to clock
- col_out  output  4  column drive, active-low one-hot
- keyPadBuf  output  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}
- key_pressed  output  1  high while an accepted key is held (until release is debounced)
- key_strobe  output  1  one-cycle pulse when a press is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=SCAN, col_idx=0, counter=0.
  - col_out=4'b1110, keyPadBuf=4'h0, key_pressed=0, key_strobe=0.
  - Reset is honoured in every state. A mid-debounce or held key is discarded and no strobe is issued.
- col_out = ~(4'b0001 << col_idx) in every state. The column stays frozen outside SCAN.
- Valid press pattern: row_in has exactly one 0. Zero or multiple 0s are not a press; multi-row ghosting is ignored.
- SCAN:
  - counter increments each cycle while col_idx is driven.
  - When counter==SETTLE-1, row_in is sampled.
    - Valid press: latch row_idx = index of the 0 bit, row_pat=row_in, counter=0, go to DEBOUNCE.
    - Otherwise: counter=0, col_idx=col_idx+1 (wraps 3->0).
  - Full sweep takes 4*SETTLE cycles.
- DEBOUNCE:
  - Each cycle compare row_in with row_pat.
    - Mismatch: counter=0, col_idx+1, go to SCAN (bounce rejected, no output change).
    - Match: counter+1.
  - On the cycle the match count reaches DEB:
    - keyPadBuf <= {row_idx, col_idx}, key_pressed <= 1, key_strobe <= 1 for exactly that one cycle.
    - counter=0, go to HELD.
  - Press latency after the first valid SCAN sample: DEB cycles to the registered outputs.
- HELD:
  - row_in==4'hF counts as a release sample (counter+1). Any other value resets counter=0, which covers release bounce.
  - When counter reaches DEB: key_pressed <= 0, counter=0, col_idx=0, go to SCAN.
  - keyPadBuf keeps the last code until the next accepted press. A second key pressed while held is ignored.
- key_strobe is 0 in all cycles except the accept cycle. At most one strobe per physical press.
- Counter arithmetic is unsigned CNT_W bits. It never wraps, because it is always cleared at its terminal value.

Test Plan:
- Reset, then idle with row_in=4'hF for 16 cycles (SETTLE=2, DEB=4) -> col_out cycles 1110, 1101, 1011, 0111, each for 2 cycles. key_pressed=0, key_strobe=0, keyPadBuf=0.
- Hold row 2 low (row_in=4'b1011) whenever col_idx=1 is driven, stable -> exactly one key_strobe, keyPadBuf=4'b1001 (4'h9), key_pressed=1. col_out stays 1101 while held.
- Release (row_in=4'hF) for 4 cycles -> key_pressed falls on the 4th cycle. Scanning resumes at col_out=1110. keyPadBuf stays 4'h9.
- Press on col 0 row 0 that bounces (row_in toggles 1110/1111 every cycle during debounce) -> no strobe, keyPadBuf unchanged. Once it is stable for 4 samples -> one strobe, keyPadBuf=4'h0.
- Two rows low simultaneously (row_in=4'b1100) -> never accepted, scanning continues, no strobe.
- Assert rst during HELD and during DEBOUNCE -> next cycle: col_out=1110, key_pressed=0, keyPadBuf=0, no strobe emitted.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low matrix keypad scanner: drives one column at a time, debounces
// press and release, and presents the accepted key code with a one-cycle strobe.
module keypad_matrix_scanner #(
    parameter int SETTLE = 2,
    parameter int DEB    = 4,
    parameter int CNT_W  = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keyPadBuf,
    output logic       key_pressed,
    output logic       key_strobe
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB - 1);

    state_t           state_reg, state_next;
    logic [1:0]       col_idx_reg, col_idx_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       row_idx_reg, row_idx_next;
    logic [3:0]       row_pat_reg, row_pat_next;
    logic [3:0]       code_reg, code_next;
    logic             pressed_reg, pressed_next;
    logic             strobe_reg, strobe_next;

    // A press is exactly one row pulled low; multi-row ghosting is rejected.
    logic [3:0] row_low;
    logic       press_valid;
    logic [1:0] sample_row;

    assign row_low     = ~row_in;
    assign press_valid = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

    always_comb begin
        sample_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_low[i]) begin
                sample_row = 2'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
            assign col_out[gi] = (col_idx_reg != 2'(gi));
        end
    endgenerate

    assign keyPadBuf   = code_reg;
    assign key_pressed = pressed_reg;
    assign key_strobe  = strobe_reg;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg   <= SCAN;
            col_idx_reg <= 2'd0;
            count_reg   <= '0;
            row_idx_reg <= 2'd0;
            row_pat_reg <= 4'hF;
            code_reg    <= 4'h0;
            pressed_reg <= 1'b0;
            strobe_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_idx_reg <= col_idx_next;
            count_reg   <= count_next;
            row_idx_reg <= row_idx_next;
            row_pat_reg <= row_pat_next;
            code_reg    <= code_next;
            pressed_reg <= pressed_next;
            strobe_reg  <= strobe_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        col_idx_next = col_idx_reg;
        count_next   = count_reg;
        row_idx_next = row_idx_reg;
        row_pat_next = row_pat_reg;
        code_next    = code_reg;
        pressed_next = pressed_reg;
        strobe_next  = 1'b0;

        unique case (state_reg)
            SCAN: begin
                if (count_reg == SETTLE_LAST) begin
                    count_next = '0;
                    if (press_valid) begin
                        row_idx_next = sample_row;
                        row_pat_next = row_in;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (row_in != row_pat_reg) begin
                    // Bounce: abandon this column and continue the sweep.
                    count_next   = '0;
                    col_idx_next = col_idx_reg + 2'd1;
                    state_next   = SCAN;
                end else if (count_reg == DEB_LAST) begin
                    code_next    = {row_idx_reg, col_idx_reg};
                    pressed_next = 1'b1;
                    strobe_next  = 1'b1;
                    count_next   = '0;
                    state_next   = HELD;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

            HELD: begin
                // Column stays frozen, so only the held key's row can pull low.
                if (row_in != 4'hF) begin
                    count_next = '0;
                end else if (count_reg == DEB_LAST) begin
                    pressed_next = 1'b0;
                    count_next   = '0;
                    col_idx_next = 2'd0;
                    state_next   = SCAN;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

            default: begin
                state_next = SCAN;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Randomized bench for keypad_matrix_scanner: a behavioural keypad drives the rows
// from the column drive, and a scoreboard matches each accepted-key strobe.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;

    localparam int SETTLE = 2;
    localparam int DEB    = 4;
    localparam int CNT_W  = 4;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] keyPadBuf;
    logic       key_pressed;
    logic       key_strobe;

    // Physical keypad model
    logic       key_active  = 1'b0;
    logic       bounce_mode = 1'b0;
    logic       multi       = 1'b0;
    logic       phase       = 1'b0;
    logic [1:0] key_row     = 2'd0;
    logic [1:0] key_col     = 2'd0;
    logic [1:0] key_row2    = 2'd0;
    logic       contact;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_code = 4'h0;

    keypad_matrix_scanner #(.SETTLE(SETTLE), .DEB(DEB), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .keyPadBuf  (keyPadBuf),
        .key_pressed(key_pressed),
        .key_strobe (key_strobe)
    );

    always #5 clock = ~clock;

    always @(negedge clock) phase <= ~phase;

    assign contact = !bounce_mode || phase;

    always_comb begin
        row_in = 4'hF;
        if (key_active && contact && !col_out[key_col]) begin
            row_in[key_row] = 1'b0;
            if (multi) row_in[key_row2] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected press.
    always @(negedge clock) begin
        if (key_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got code %h expected no strobe at %0t", keyPadBuf, $time);
            end else begin
                logic [3:0] code;
                code = exp_q.pop_front();
                check("strobe_code", keyPadBuf, code);
                check("strobe_pressed", {3'b0, key_pressed}, 4'd1);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Press a key stably, confirm acceptance while held, leave it held.
    task automatic hold_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] col_exp;
        key_row = r; key_col = c; multi = 1'b0; bounce_mode = 1'b0;
        exp_q.push_back({r, c});
        key_active = 1'b1;
        wait_cycles(20 + int'($urandom_range(0, 10)));
        col_exp = ~(4'b0001 << c);
        check("accepted", 4'(exp_q.size()), 4'd0);
        check("held_pressed", {3'b0, key_pressed}, 4'd1);
        check("held_col", col_out, col_exp);
        last_code = {r, c};
    endtask

    task automatic release_key();
        key_active = 1'b0; bounce_mode = 1'b0; multi = 1'b0;
        wait_cycles(DEB - 1);
        check("release_early", {3'b0, key_pressed}, 4'd1);
        wait_cycles(1);
        check("release_pressed", {3'b0, key_pressed}, 4'd0);
        check("release_code", keyPadBuf, last_code);
        check("release_col", col_out, 4'b1110);
        wait_cycles(2);
    endtask

    task automatic press_stable(input logic [1:0] r, input logic [1:0] c);
        $display("txn stable row=%0d col=%0d", r, c);
        hold_key(r, c);
        release_key();
    endtask

    task automatic press_bounce(input logic [1:0] r, input logic [1:0] c);
        $display("txn bounce row=%0d col=%0d", r, c);
        key_row = r; key_col = c; multi = 1'b0;
        bounce_mode = 1'b1;
        key_active  = 1'b1;
        wait_cycles(16 + int'($urandom_range(0, 8)));
        check("bounce_pressed", {3'b0, key_pressed}, 4'd0);
        check("bounce_code", keyPadBuf, last_code);
        hold_key(r, c);
        release_key();
    endtask

    task automatic press_multi(input logic [1:0] r, input logic [1:0] c, input logic [1:0] r2);
        $display("txn multi rows=%0d,%0d col=%0d", r, r2, c);
        key_row = r; key_col = c; key_row2 = r2; bounce_mode = 1'b0;
        multi = 1'b1;
        key_active = 1'b1;
        wait_cycles(24);
        check("multi_pressed", {3'b0, key_pressed}, 4'd0);
        check("multi_code", keyPadBuf, last_code);
        key_active = 1'b0; multi = 1'b0;
        wait_cycles(4);
    endtask

    initial begin
        logic [3:0] col_exp;
        logic [1:0] r, c, r2;
        int         kind;

        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        check("reset_col", col_out, 4'b1110);
        check("reset_code", keyPadBuf, 4'h0);
        check("reset_pressed", {3'b0, key_pressed}, 4'd0);
        check("reset_strobe", {3'b0, key_strobe}, 4'd0);

        // Idle sweep: each column driven for SETTLE cycles in turn.
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clock);
            col_exp = ~(4'b0001 << ((k / SETTLE) % 4));
            check("idle_col", col_out, col_exp);
            check("idle_strobe", {3'b0, key_strobe}, 4'd0);
        end
        $display("txn idle sweep 16 cycles");

        // Reset while a press is being debounced.
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        key_row = 2'd0; key_col = 2'd0; key_active = 1'b1;
        wait_cycles(3);
        rst = 1'b1; key_active = 1'b0;
        wait_cycles(1);
        check("rst_deb_col", col_out, 4'b1110);
        check("rst_deb_pressed", {3'b0, key_pressed}, 4'd0);
        check("rst_deb_code", keyPadBuf, 4'h0);
        check("rst_deb_strobe", {3'b0, key_strobe}, 4'd0);
        rst = 1'b0;
        $display("txn reset during debounce");
        wait_cycles(2);

        press_stable(2'd2, 2'd1);
        press_bounce(2'd0, 2'd0);
        press_multi(2'd0, 2'd1, 2'd1);

        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 3));
            r    = 2'($urandom_range(0, 3));
            c    = 2'($urandom_range(0, 3));
            r2   = 2'((int'(r) + 1 + int'($urandom_range(0, 2))) % 4);
            case (kind)
                2:       press_bounce(r, c);
                3:       press_multi(r, c, r2);
                default: press_stable(r, c);
            endcase
        end

        // Reset while a key is held.
        $display("txn reset during held");
        hold_key(2'd3, 2'd2);
        rst = 1'b1; key_active = 1'b0;
        wait_cycles(1);
        check("rst_held_col", col_out, 4'b1110);
        check("rst_held_pressed", {3'b0, key_pressed}, 4'd0);
        check("rst_held_code", keyPadBuf, 4'h0);
        check("rst_held_strobe", {3'b0, key_strobe}, 4'd0);
        rst = 1'b0;
        last_code = 4'h0;
        wait_cycles(20);
        check("final_queue", 4'(exp_q.size()), 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
